// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: key codes, matrix size, debounce FSM states and
// the frame-priority helper.
package keypad_defs;
  localparam logic [4:0] KEY_NONE = 5'd0;
  localparam logic [4:0] KEY_BASE = 5'd4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } deb_state_e;

  // Bit index is 4*row+col; scanning downwards leaves the lowest pressed code.
  function automatic logic [4:0] lowest_key(input logic [NUM_ROWS*NUM_COLS-1:0] bits);
    logic [4:0] code;
    code = KEY_NONE;
    for (int i = NUM_ROWS*NUM_COLS-1; i >= 0; i--)
      if (bits[i]) code = KEY_BASE + 5'(i);
    return code;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the debounced key output of the scanner.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [4:0] keycode;
  logic       ready;

  modport master (output row_n, keycode, ready, input col_n);
  modport slave  (input row_n, keycode, ready, output col_n);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Debounce FSM: a frame code must repeat DEBOUNCE_FRAMES times before it
// replaces the registered keycode/ready pair.
module keypad_debounce
  import keypad_defs::*;
#(
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  logic [4:0] frame_code,
  output logic [4:0] keycode,
  output logic       ready
);
  logic [4:0] cand_q;
  logic [7:0] cnt_q;
  logic [4:0] keycode_q;
  logic       ready_q;
  deb_state_e state_q;

  // CONFIRM is held exactly while the candidate differs from the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= KEY_NONE;
      cnt_q     <= '0;
      keycode_q <= KEY_NONE;
      ready_q   <= 1'b0;
      state_q   <= IDLE;
    end else if (frame_valid) begin
      if (frame_code != cand_q) begin
        cand_q <= frame_code;
        cnt_q  <= 8'd1;
        if (frame_code != keycode_q)    state_q <= CONFIRM;
        else if (keycode_q == KEY_NONE) state_q <= IDLE;
        else                            state_q <= HELD;
      end else if (cnt_q != 8'(DEBOUNCE_FRAMES)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else if (state_q == CONFIRM && cnt_q == 8'(DEBOUNCE_FRAMES)) begin
      keycode_q <= cand_q;
      ready_q   <= (cand_q != KEY_NONE);
      state_q   <= (cand_q != KEY_NONE) ? HELD : IDLE;
    end
  end

  assign keycode = keycode_q;
  assign ready   = ready_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row rotation, column synchronizer, frame encoding and
// debounce. Define KEYPAD_GHOST_REJECT_EN to report multi-key frames as no key.
module keypad_scanner
  import keypad_defs::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);
  logic [3:0]  col_s1_q, col_s2_q;
  logic [15:0] div_q;
  logic [1:0]  row_q;
  logic [3:0]  row_n_q;
  logic [11:0] press_q;
  logic        sample;
  logic        frame_valid;
  logic [15:0] frame_bits;
  logic [4:0]  frame_code;

  assign sample      = (div_q == 16'(SCAN_DIV - 1));
  assign frame_valid = sample && (row_q == 2'd3);
  // Rows 0..2 come from the stored samples, row 3 is taken live on its edge.
  assign frame_bits  = {~col_s2_q, press_q};

`ifdef KEYPAD_GHOST_REJECT_EN
  assign frame_code = ((frame_bits & (frame_bits - 16'd1)) != '0) ? KEY_NONE
                                                                  : lowest_key(frame_bits);
`else
  assign frame_code = lowest_key(frame_bits);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
      div_q    <= '0;
      row_q    <= '0;
      row_n_q  <= 4'b1110;
      press_q  <= '0;
    end else begin
      col_s1_q <= kp.col_n;
      col_s2_q <= col_s1_q;
      if (sample) begin
        div_q   <= '0;
        row_q   <= row_q + 2'd1;
        row_n_q <= {row_n_q[2:0], row_n_q[3]};
        if (row_q != 2'd3) press_q[{row_q, 2'b00} +: 4] <= ~col_s2_q;
      end else begin
        div_q <= div_q + 16'd1;
      end
    end
  end

  assign kp.row_n = row_n_q;

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_valid(frame_valid),
    .frame_code (frame_code),
    .keycode    (kp.keycode),
    .ready      (kp.ready)
  );
endmodule
